// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: 3-bit opcode encoding and the sequencer states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND      = 3'd0,
        OP_NOT      = 3'd1,
        OP_OR       = 3'd2,
        OP_XOR      = 3'd3,
        OP_ADD      = 3'd4,
        OP_SUB      = 3'd5,
        OP_TRANSFER = 3'd6,
        OP_TEST     = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only ADD and SUB propagate a carry/borrow between bit slices.
    function automatic logic is_arith(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial4_if.sv
// Request/result bundle for alu_serial4; the zero port exists only with ALU_SERIAL4_ZERO_FLAG_EN.
// master = requester (drives operands/start), slave = the ALU.
interface alu_serial4_if #(parameter int WIDTH = 4);

    logic             start;
    logic [2:0]       select;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

`ifdef ALU_SERIAL4_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, select, a, b, carry_in,
        input  busy, done, result, carry_out, zero
    );

    modport slave (
        input  start, select, a, b, carry_in,
        output busy, done, result, carry_out, zero
    );
`else
    modport master (
        output start, select, a, b, carry_in,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, select, a, b, carry_in,
        output busy, done, result, carry_out
    );
`endif

endinterface

// File: rtl/alu1.sv
// One-bit ALU slice, purely combinational; carry_out is meaningful only for ADD (carry) and SUB (borrow).
module alu1
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    carry_in,
    input  opcode_t select,
    output logic    out,
    output logic    carry_out
);

    always_comb begin
        out       = 1'b0;
        carry_out = 1'b0;
        case (select)
            OP_AND:      out = a & b;
            OP_NOT:      out = ~a;
            OP_OR:       out = a | b;
            OP_XOR:      out = a ^ b;
            OP_ADD: begin
                out       = a ^ b ^ carry_in;
                carry_out = (a & b) | (carry_in & (a ^ b));
            end
            OP_SUB: begin
                // carry_in/carry_out act as borrow-in/borrow-out here
                out       = a ^ b ^ carry_in;
                carry_out = (~a & b) | (carry_in & ~(a ^ b));
            end
            OP_TRANSFER: out = a;
            OP_TEST:     out = ~(a ^ b);
            default: begin
                out       = 1'b0;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial4.sv
// Bit-serial ALU, one alu1 slice per cycle LSB first; done pulses WIDTH edges after start, throughput WIDTH+2.
// start is only sampled in IDLE (ignored while busy); optional zero flag under ALU_SERIAL4_ZERO_FLAG_EN.
module alu_serial4
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
)(
    input  logic         clk,
    input  logic         rst_n,
    alu_serial4_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    opcode_t          op_q;
    opcode_t          sel_op;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             cell_out;
    logic             cell_carry;

    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;

    assign sel_op  = opcode_t'(bus.select);
    assign acc_nxt = {cell_out, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right so the slice always sees bit 0; the cell output
    // enters at the MSB so after WIDTH steps bit i sits at acc[i].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            op_q    <= sel_op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            acc_q   <= '0;
            carry_q <= is_arith(sel_op) & bus.carry_in;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            acc_q   <= acc_nxt;
            carry_q <= is_arith(op_q) & cell_carry;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    alu1 u_cell (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .select    (op_q),
        .out       (cell_out),
        .carry_out (cell_carry)
    );

    // Visible result only moves on the final slice, so it is stable for a whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else if (last) begin
            result_q    <= acc_nxt;
            carry_out_q <= is_arith(op_q) & cell_carry;
        end
    end

`ifdef ALU_SERIAL4_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else if (last) begin
            zero_q <= (acc_nxt == '0);
        end
    end

    assign bus.zero = zero_q;
`else
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;

endmodule

// File: doc/alu_serial4.md
ALU_SERIAL4 -- requirements
Module: alu_serial4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port select, input, 3 bits: opcode from alu_pkg, sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start.
REQ-007 The block SHALL have port carry_in, input, 1 bit: carry-in for ADD, borrow-in for SUB, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port result, output, WIDTH bits: registered operation result.
REQ-011 The block SHALL have port carry_out, output, 1 bit: final carry (ADD) or borrow (SUB), else 0.
REQ-012 The block SHALL have port zero, output, 1 bit, present only under ALU_SERIAL4_ZERO_FLAG_EN: high when result is 0.

Function
REQ-013 The block SHALL be a bit-serial initiator driving one alu1 cell per cycle, LSB first; the opcodes SHALL be AND=0, NOT=1, OR=2, XOR=3, ADD=4, SUB=5, TRANSFER=6, TEST=7.
REQ-014 The state machine SHALL use IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after bit WIDTH-1; DONE->IDLE unconditionally.
REQ-015 On accepting start, the block SHALL latch a, b, select and carry_in into internal registers and clear the bit counter.
REQ-016 In RUN, the alu1 cell SHALL receive operand bit[i], the latched select and the carry register; the cell out SHALL shift into result MSB-first-fill so that bit i lands at result[i], and the cell carry_out SHALL update the carry register.
REQ-017 The carry register SHALL chain only for ADD and SUB; for the other opcodes it SHALL be held at 0 and final carry_out SHALL be 0.
REQ-018 done SHALL be high for exactly one cycle, asserted after the WIDTH-th rising edge following the edge that sampled start (edge 0), i.e. in state DONE.
REQ-019 result and carry_out SHALL update only when done rises, and SHALL hold until the next completion; the partial result is internal.
REQ-020 start SHALL be ignored in RUN and DONE; new operands applied while busy SHALL have no effect.
REQ-021 Back-to-back operation SHALL be possible: start sampled in the IDLE cycle immediately after DONE is accepted (throughput WIDTH+2 cycles).
REQ-022 Arithmetic SHALL be modulo 2^WIDTH: ADD gives {carry_out,result} = a+b+carry_in; SUB gives result = a-b-carry_in with carry_out=1 on underflow.
REQ-023 TEST SHALL give result[i] = (a[i]==b[i]); TRANSFER SHALL give result = a; NOT SHALL give result = ~a.

Reset
REQ-024 While rst_n is low, the block SHALL force state IDLE and drive busy=0, done=0, result=0, carry_out=0, zero=1, with all internal registers cleared, asynchronously.
REQ-025 Reset asserted mid-operation SHALL abort the operation without a done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 When ALU_SERIAL4_ZERO_FLAG_EN is defined, the zero port SHALL exist and be registered with result (zero = result==0, updated with done); when undefined, the port and its logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-027 Package alu_pkg SHALL hold the 3-bit opcode enum and the IDLE/RUN/DONE state enum.
REQ-028 alu_serial4 SHALL instantiate exactly one existing alu1 as its datapath sub-module; counter, shift registers and FSM SHALL be local.

Verification
REQ-029 The bench SHALL cover ADD a=0111 b=0011 cin=0 -> result=1010, carry_out=0, done after exactly 4 edges past start, busy high for 5 cycles.
REQ-030 The bench SHALL cover ADD a=1111 b=0001 cin=0 -> result=0000, carry_out=1, zero=1 (macro on).
REQ-031 The bench SHALL cover SUB a=0011 b=0101 cin=0 -> result=1110, carry_out=1; SUB a=0101 b=0011 -> 0010, carry_out=0.
REQ-032 The bench SHALL cover XOR a=1100 b=1010 with start re-pulsed mid-RUN using a=0000 -> result=0110, a single done, and the second start ignored.
REQ-033 The bench SHALL cover rst_n pulsed low at bit 2 of ADD 0111+0001 -> no done, result=0, busy=0; a following TEST a=1001 b=1011 -> result=1101.
REQ-034 The bench SHALL sweep all eight opcodes over exhaustive 4-bit operand pairs and both carry_in values against a reference model, and check the single done pulse on every operation.
